map_mem_arbiter: RTL

//  Shares the single SDRAM port between the mapper PRG read path, the CHR read/write path and the host loader.

---
 rtl/map_pkg.sv | 23 ++
 rtl/map_req_slot.sv | 86 ++++++++
 rtl/map_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared types and helpers for the mapper SDRAM arbiter.
// Holds the arbiter FSM states, the port identifiers and the starvation counter width helper.
package map_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef enum logic [1:0] {
        PORT_PRG,
        PORT_CHR,
        PORT_HOST
    } arb_port_t;

    // Width needed to hold 0..limit inclusive.
    function automatic int unsigned starve_cnt_bits(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/map_req_slot.sv
// One pending-request slot: rising-edge capture of read/write strobes plus address/data latch.
// A fresh edge is exposed combinationally so an idle arbiter can grant it in the same cycle.
module map_req_slot
    import map_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 23
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 rd_stb,
    input  logic                 wr_stb,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 clr,
    output logic                 req,
    output logic [ADDR_BITS-1:0] req_addr,
    output logic                 req_we,
    output logic [DATA_BITS-1:0] req_wdata
);

    logic                 rd_q;
    logic                 wr_q;
    logic                 pend_q, pend_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;

    logic rd_rise;
    logic wr_rise;
    logic hit;

    assign rd_rise = rd_stb & ~rd_q;
    assign wr_rise = wr_stb & ~wr_q;
    assign hit     = run & (rd_rise | wr_rise);

    // A held slot is older than a same-cycle edge, so it is offered first.
    always_comb begin
        req       = run & (pend_q | hit);
        req_addr  = pend_q ? addr_q  : addr;
        req_we    = pend_q ? we_q    : wr_rise;
        req_wdata = pend_q ? wdata_q : wdata;
    end

    always_comb begin
        pend_d  = pend_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        if (clr) begin
            pend_d = 1'b0;
        end
        if (hit) begin
            // When the held entry was just granted, the new edge re-arms the slot;
            // when the edge itself was granted via bypass, nothing stays pending.
            pend_d = clr ? pend_q : 1'b1;
            addr_d = addr;
            we_d   = wr_rise;
            if (wr_rise) begin
                wdata_d = wdata;
            end
        end
        if (!run) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            rd_q    <= rd_stb;
            wr_q    <= wr_stb;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: rtl/map_mem_arbiter.sv
// Shares the SDRAM port between mapper PRG reads, CHR reads/writes and the host loader.
// Fixed priority CHR > PRG > host, with a one-shot promotion for a starved host request.
module map_mem_arbiter
    import map_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 23,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [ADDR_BITS-1:0] prg_addr,
    input  logic                 prg_oe,
    output logic [DATA_BITS-1:0] prg_data,
    input  logic [ADDR_BITS-1:0] chr_addr,
    input  logic                 chr_oe,
    input  logic                 chr_we,
    input  logic [DATA_BITS-1:0] chr_wdata,
    output logic [DATA_BITS-1:0] chr_data,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [DATA_BITS-1:0] host_wdata,
    output logic                 host_ack,
    output logic [DATA_BITS-1:0] host_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    localparam int unsigned CNT_BITS = starve_cnt_bits(STARVE_LIMIT);
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(STARVE_LIMIT);

    arb_state_t           state_q, state_d;
    arb_port_t            port_q, port_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_BITS-1:0] prg_data_q, prg_data_d;
    logic [DATA_BITS-1:0] chr_data_q, chr_data_d;
    logic [DATA_BITS-1:0] host_rdata_q, host_rdata_d;
    logic                 host_ack_q, host_ack_d;
    logic [CNT_BITS-1:0]  starve_q, starve_d;

    logic                 prg_req, prg_req_we, prg_clr;
    logic [ADDR_BITS-1:0] prg_req_addr;
    logic [DATA_BITS-1:0] prg_req_wdata;
    logic                 chr_req, chr_req_we, chr_clr;
    logic [ADDR_BITS-1:0] chr_req_addr;
    logic [DATA_BITS-1:0] chr_req_wdata;

    logic      host_pend;
    logic      host_grant;
    logic      promote;
    logic      win_valid;
    arb_port_t win_port;

    map_req_slot #(
        .ADDR_BITS(ADDR_BITS)
    ) u_prg_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .rd_stb   (prg_oe),
        .wr_stb   (1'b0),
        .addr     (prg_addr),
        .wdata    ('0),
        .clr      (prg_clr),
        .req      (prg_req),
        .req_addr (prg_req_addr),
        .req_we   (prg_req_we),
        .req_wdata(prg_req_wdata)
    );

    map_req_slot #(
        .ADDR_BITS(ADDR_BITS)
    ) u_chr_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .rd_stb   (chr_oe),
        .wr_stb   (chr_we),
        .addr     (chr_addr),
        .wdata    (chr_wdata),
        .clr      (chr_clr),
        .req      (chr_req),
        .req_addr (chr_req_addr),
        .req_we   (chr_req_we),
        .req_wdata(chr_req_wdata)
    );

    // host_ack_q masks the cycle in which the host still holds host_req after completion.
    assign host_pend = host_req & ~host_ack_q &
                       ~((state_q == ARB_BUSY) && (port_q == PORT_HOST));
    assign promote   = (starve_q == CNT_MAX);

    always_comb begin
        win_valid = 1'b0;
        win_port  = PORT_PRG;
        if (state_q == ARB_IDLE) begin
            if (promote && host_pend) begin
                win_valid = 1'b1;
                win_port  = PORT_HOST;
            end else if (chr_req) begin
                win_valid = 1'b1;
                win_port  = PORT_CHR;
            end else if (prg_req) begin
                win_valid = 1'b1;
                win_port  = PORT_PRG;
            end else if (host_pend) begin
                win_valid = 1'b1;
                win_port  = PORT_HOST;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        prg_data_d   = prg_data_q;
        chr_data_d   = chr_data_q;
        host_rdata_d = host_rdata_q;
        host_ack_d   = 1'b0;
        starve_d     = starve_q;
        prg_clr      = 1'b0;
        chr_clr      = 1'b0;
        host_grant   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d   = ARB_BUSY;
                    port_d    = win_port;
                    mem_req_d = 1'b1;
                    case (win_port)
                        PORT_CHR: begin
                            mem_addr_d  = chr_req_addr;
                            mem_we_d    = chr_req_we;
                            mem_wdata_d = chr_req_wdata & {DATA_BITS{chr_req_we}};
                            chr_clr     = 1'b1;
                        end
                        PORT_PRG: begin
                            mem_addr_d  = prg_req_addr;
                            mem_we_d    = prg_req_we;
                            mem_wdata_d = prg_req_wdata & {DATA_BITS{prg_req_we}};
                            prg_clr     = 1'b1;
                        end
                        default: begin
                            mem_addr_d  = host_addr;
                            mem_we_d    = host_we;
                            mem_wdata_d = host_wdata & {DATA_BITS{host_we}};
                            host_grant  = 1'b1;
                        end
                    endcase
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        case (port_q)
                            PORT_PRG: prg_data_d   = mem_rdata;
                            PORT_CHR: chr_data_d   = mem_rdata;
                            default:  host_rdata_d = mem_rdata;
                        endcase
                    end
                    host_ack_d = (port_q == PORT_HOST);
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (host_grant) begin
            starve_d = '0;
        end else if (host_pend && !promote) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            port_q       <= PORT_PRG;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            prg_data_q   <= '0;
            chr_data_q   <= '0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            prg_data_q   <= prg_data_d;
            chr_data_q   <= chr_data_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
            starve_q     <= starve_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign prg_data   = prg_data_q;
    assign chr_data   = chr_data_q;
    assign host_rdata = host_rdata_q;
    assign host_ack   = host_ack_q;

endmodule
